// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and load lane extraction for the data memory
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    typedef struct packed {
        logic       we;
        logic       err;
        logic [1:0] size;
        logic [1:0] lane;
        logic       uns;
    } rsp_info_t;

    // word is big-endian {lane0, lane1, lane2, lane3}; shifting left by lane
    // brings the first addressed byte to bits 31:24.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] sh;
        sh = word << {lane, 3'b000};
        case (size)
            SIZE_B:  return uns ? {24'b0, sh[31:24]} : {{24{sh[31]}}, sh[31:24]};
            SIZE_H:  return uns ? {16'b0, sh[31:16]} : {{16{sh[31]}}, sh[31:16]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// rtl/data_memory_bytelane_if.sv - request/response bus between a datapath and the data memory
interface data_memory_bytelane_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_byte_bank.sv
// rtl/dmem_byte_bank.sv - one 8-bit byte lane with synchronous write and registered read
module dmem_byte_bank #(
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [1 << ROW_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - big-endian byte-addressable data memory with init clear and access checks
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input logic                   clk,
    input logic                   rst,
    data_memory_bytelane_if.slave bus
);
    localparam int LOG2  = $clog2(DEPTH_BYTES);
    localparam int ROW_W = LOG2 - 2;
    localparam int ROWS  = DEPTH_BYTES / 4;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] clr_ptr;
    logic             ready;
    logic             clearing;

    logic [1:0]       lane;
    logic [ROW_W-1:0] row;
    logic             err;
    logic             accept;
    logic [ROW_W-1:0] bank_row;
    logic             lane_we [4];
    logic [7:0]       lane_wd [4];
    logic [7:0]       lane_rd [4];

    rsp_info_t        info_q;
    logic             rsp_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (clr_ptr == ROW_W'(ROWS - 1)) state_d = IDLE;
            IDLE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        clearing = 1'b0;
        case (state_q)
            INIT:    clearing = 1'b1;
            IDLE:    ready    = 1'b1;
            default: clearing = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_ptr <= '0;
        end else if (clearing) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    assign lane   = bus.req_addr[1:0];
    assign row    = bus.req_addr[LOG2-1:2];
    assign accept = bus.req_valid & ready;

    always_comb begin
        err = 1'b0;
        if (bus.req_size == 2'b11)                        err = 1'b1;
        if (bus.req_size == SIZE_H && bus.req_addr[0])    err = 1'b1;
        if (bus.req_size == SIZE_W && lane != 2'b00)      err = 1'b1;
        if (bus.req_addr >= ADDR_W'(DEPTH_BYTES))         err = 1'b1;
    end

    assign bank_row = clearing ? clr_ptr : row;

    // Halfword: the lower-addressed lane takes the high byte of wdata.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_we[i] = 1'b0;
            lane_wd[i] = 8'h00;
            if (clearing) begin
                lane_we[i] = 1'b1;
            end else if (accept && bus.req_we && !err) begin
                case (bus.req_size)
                    SIZE_B: begin
                        lane_we[i] = (2'(i) == lane);
                        lane_wd[i] = bus.req_wdata[7:0];
                    end
                    SIZE_H: begin
                        lane_we[i] = (i / 2 == int'(lane[1]));
                        lane_wd[i] = (2'(i) == lane) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
                    end
                    default: begin
                        lane_we[i] = 1'b1;
                        lane_wd[i] = bus.req_wdata[8*(3-i) +: 8];
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        dmem_byte_bank #(
            .ROW_W(ROW_W)
        ) u_bank (
            .clk  (clk),
            .we   (lane_we[g]),
            .addr (bank_row),
            .wdata(lane_wd[g]),
            .rdata(lane_rd[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            info_q      <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                info_q <= '{we: bus.req_we, err: err, size: bus.req_size,
                            lane: lane, uns: bus.req_unsigned};
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_valid_q & info_q.err;
    assign bus.rsp_rdata = (rsp_valid_q && !info_q.err && !info_q.we)
                         ? lane_extract({lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]},
                                        info_q.size, info_q.lane, info_q.uns)
                         : 32'h0;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - randomized and directed checks of data_memory_bytelane against a byte-array model
module tb_data_memory_bytelane;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] model_mem [DEPTH];

    data_memory_bytelane_if #(.ADDR_W(32)) bus ();

    data_memory_bytelane #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    endtask

    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
        int n;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
           || (size == 2'd2 && addr % 4 != 0) || (addr >= DEPTH);
        rdata = 32'h0;
        if (err) return;
        n = 1 << size;
        if (we) begin
            for (int k = 0; k < n; k++)
                model_mem[addr + k] = 8'((wdata >> (8 * (n - 1 - k))) & 32'hFF);
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(model_mem[addr + k]);
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
            rdata = v;
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic e;
        logic [31:0] d;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        check_val({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        model_access(we, size, uns, addr, wdata, e, d);
        check_val({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        check_val({tag, ".err"}, 32'(bus.rsp_err), 32'(e));
        check_val({tag, ".rdata"}, bus.rsp_rdata, d);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, ".valid_low"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus.req_ready && cnt < 2000);
        check_val({tag, ".init_cycles"}, 32'(cnt), 32'(DEPTH / 4));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check_val({tag, ".rst_ready"}, 32'(bus.req_ready), 32'd0);
        check_val({tag, ".rst_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_val({tag, ".rst_rdata"}, bus.rsp_rdata, 32'd0);
        check_val({tag, ".rst_err"}, 32'(bus.rsp_err), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        reset_pulse("por");
        wait_init("por");

        xact("lw0", 0, 2'd2, 0, 32'h000, 0);
        xact("lw3fc", 0, 2'd2, 0, 32'h3FC, 0);

        xact("sw10", 1, 2'd2, 0, 32'h10, 32'h11223344);
        xact("lb10", 0, 2'd0, 0, 32'h10, 0);
        xact("lbu13", 0, 2'd0, 1, 32'h13, 0);
        xact("lh12", 0, 2'd1, 0, 32'h12, 0);
        xact("lw10", 0, 2'd2, 0, 32'h10, 0);
        check_val("lw10.const", bus.rsp_rdata, 32'h11223344);

        xact("sb21", 1, 2'd0, 0, 32'h21, 32'h000000F0);
        xact("lb21", 0, 2'd0, 0, 32'h21, 0);
        check_val("lb21.const", bus.rsp_rdata, 32'hFFFFFFF0);
        xact("lbu21", 0, 2'd0, 1, 32'h21, 0);
        xact("lw20", 0, 2'd2, 0, 32'h20, 0);
        check_val("lw20.const", bus.rsp_rdata, 32'h00F00000);

        xact("sw30", 1, 2'd2, 0, 32'h30, 32'hA1B2C3D4);
        xact("sh31", 1, 2'd1, 0, 32'h31, 32'hFFFF);
        xact("lw32", 0, 2'd2, 0, 32'h32, 0);
        xact("sz11", 1, 2'd3, 0, 32'h30, 32'h0);
        xact("lw400", 0, 2'd2, 0, 32'h400, 0);
        check_val("lw400.err_const", 32'(bus.rsp_err), 32'd1);
        xact("sw400", 1, 2'd2, 0, 32'h400, 32'hDEADBEEF);
        xact("lw30", 0, 2'd2, 0, 32'h30, 0);
        check_val("lw30.const", bus.rsp_rdata, 32'hA1B2C3D4);
        idle_cycle("pre_b2b");

        xact("b2b_sw", 1, 2'd2, 0, 32'h40, 32'hCAFEBABE);
        xact("b2b_lw", 0, 2'd2, 0, 32'h40, 0);
        check_val("b2b_lw.const", bus.rsp_rdata, 32'hCAFEBABE);
        idle_cycle("post_b2b");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1000, 1100)) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) idle_cycle("rnd_gap");
            xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int a = 0; a < 64; a += 4) xact("sweep", 0, 2'd2, 0, 32'(a), 0);
        idle_cycle("post_rnd");

        // Reset part-way through init, then again right after a store is accepted.
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        reset_pulse("mid_init");
        wait_init("mid_init");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h50;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check_val("sw50_rst.valid", 32'(bus.rsp_valid), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("sw50_rst.valid2", 32'(bus.rsp_valid), 32'd0);
        wait_init("post_sw50");
        xact("lw50", 0, 2'd2, 0, 32'h50, 0);
        check_val("lw50.const", bus.rsp_rdata, 32'h0);
        idle_cycle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised, byte-addressable, big-endian data memory for the single-cycle and multicycle datapaths. It serves byte, halfword and word loads and stores, with sign or zero extension on loads. Stores write only the addressed byte lanes. Misaligned, illegal-size and out-of-range accesses are flagged instead of silently corrupting neighbouring bytes. After every reset, an init sequencer clears the whole array before the block accepts requests.

## Interface
Parameters:
- DEPTH_BYTES, 1024: storage size in bytes; must be a multiple of 4 and a power of two.
- ADDR_W, 32: request address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: response for the accepted request.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  accepted request was misaligned, illegal-size or out of range.

## Operation
- Storage consists of 4 byte lanes, each DEPTH_BYTES/4 entries.
  - Lane index = addr[1:0]; row = addr[log2(DEPTH_BYTES)-1:2].
  - Byte order is big-endian: lane 0 holds bits 31:24 of the word.
- Accept = req_valid & req_ready. There is no response backpressure; rsp is always consumed.
- Error conditions, checked in this order and all yielding the same outcome:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr ≥ DEPTH_BYTES.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Stores: byte writes wdata[7:0] to lane addr[1:0]. Half writes wdata[15:8] to addr and wdata[7:0] to addr+1. Word writes wdata[31:24..7:0] to addr..addr+3. All other lanes are untouched.
- Loads: the addressed bytes are concatenated in address order, right-justified, then extended to 32 bits per req_unsigned. For word loads, req_unsigned is ignored.
- FSM states:
  - INIT: req_ready=0; clears one row (all 4 lanes) per cycle; clr_ptr increments from 0. When clr_ptr = DEPTH_BYTES/4−1 is cleared, go to IDLE.
  - IDLE: req_ready=1; serves one request per cycle.

## Timing
- Reset values: state=INIT, clr_ptr=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Reset asserted mid-operation (any state, including mid-INIT): outputs go to reset values immediately. Any in-flight response is dropped. Array contents are re-cleared after release.
- Init duration: DEPTH_BYTES/4 rising edges after rst release. req_ready rises after the edge that clears the last row (256 edges at default).
- Latency: a request accepted at edge N gives rsp_valid=1 for exactly the cycle following edge N+1's setup, i.e. it is registered at edge N and low again after edge N+1 unless a new request was accepted at N+1.
- Throughput: one request per cycle; back-to-back requests give a continuous rsp_valid.
- Read-after-write: a store accepted at edge N is visible to a load accepted at edge N+1.
- Write and read are never concurrent (one request per cycle), so there is no same-address collision case.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state enum {INIT, IDLE};
  - the lane-extract/extend function.
- Sub-module dmem_byte_bank: one 8-bit-wide lane with a synchronous write enable and a registered read port (clk only, no reset on storage). It is instantiated 4 times.
- Top level holds the FSM, clr_ptr, decode/error logic, the registered response-side size, lane and unsigned info, and the output mux.

## Test plan
- Reset release → req_ready=0 for 256 cycles at default; then LW 0x000, 0x3FC → rdata 0x00000000, err 0.
- SW 0x10 data 0x11223344; LB 0x10 → 0x00000011; LBU 0x13 → 0x00000044; LH 0x12 → 0x00003344; LW 0x10 → 0x11223344.
- SB 0x21 data 0x000000F0 over a zeroed word; LB 0x21 → 0xFFFFFFF0; LBU 0x21 → 0x000000F0; LW 0x20 → 0x00F00000.
- SH 0x31, LW 0x32, size 11, LW 0x400 → each rsp_err=1, rdata=0; a following LW 0x30 shows the word unchanged.
- Back-to-back SW 0x40 data 0xCAFEBABE then LW 0x40 on consecutive cycles → rsp_valid high 2 cycles; second rdata = 0xCAFEBABE.
- Assert rst for 1 cycle at cycle 100 of init and again just after an SW 0x50 → rsp_valid stays 0; a full re-init follows; LW 0x50 → 0.
